// File: rtl/y86_defs.sv
// Shared Y86-64 pipeline definitions: instruction codes, status codes,
// and the M/W pipeline register layouts with their bubble values.
package y86_defs;

    localparam int WORD = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_BUB = 3'd0;
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_ADR = 3'd2;
    localparam logic [2:0] S_INS = 3'd3;
    localparam logic [2:0] S_HLT = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0]      stat;
        logic [3:0]      icode;
        logic            cnd;
        logic [WORD-1:0] val_e;
        logic [WORD-1:0] val_a;
        logic [3:0]      dst_e;
        logic [3:0]      dst_m;
    } m_reg_t;

    typedef struct packed {
        logic [2:0]      stat;
        logic [3:0]      icode;
        logic [WORD-1:0] val_e;
        logic [WORD-1:0] val_m;
        logic [3:0]      dst_e;
        logic [3:0]      dst_m;
    } w_reg_t;

    localparam m_reg_t M_BUBBLE = '{stat: S_BUB, icode: I_NOP, cnd: 1'b0,
                                    val_e: '0, val_a: '0,
                                    dst_e: RNONE, dst_m: RNONE};

    localparam w_reg_t W_BUBBLE = '{stat: S_BUB, icode: I_NOP,
                                    val_e: '0, val_m: '0,
                                    dst_e: RNONE, dst_m: RNONE};

endpackage

// File: rtl/data_mem.sv
// Byte-addressable data memory: combinational 8-byte little-endian read,
// clocked stage write, and a program-load port that loses per byte to the stage.
module data_mem #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        error,
    input  logic        ld_en,
    input  logic [63:0] ld_addr,
    input  logic [63:0] ld_data
);

    localparam int          AW   = $clog2(MEM_BYTES);
    localparam logic [63:0] LAST = 64'(MEM_BYTES - 8);

    logic [7:0]    mem [MEM_BYTES];
    logic          in_range;
    logic          ld_in_range;
    logic [AW-1:0] base;
    logic [AW-1:0] ld_base;

    assign in_range    = (addr <= LAST);
    assign ld_in_range = (ld_addr <= LAST);
    assign base        = addr[AW-1:0];
    assign ld_base     = ld_addr[AW-1:0];
    assign error       = (rd | wr) & ~in_range;

    always_comb begin
        rdata = '0;
        if (rd && in_range) begin
            for (int i = 0; i < 8; i++)
                rdata[8*i +: 8] = mem[base + AW'(i)];
        end
    end

    // Stage write is issued after the load-port write so it wins on overlapping bytes.
    always_ff @(posedge clock) begin
        if (ld_en && ld_in_range) begin
            for (int i = 0; i < 8; i++)
                mem[ld_base + AW'(i)] <= ld_data[8*i +: 8];
        end
        if (wr && in_range && !reset) begin
            for (int i = 0; i < 8; i++)
                mem[base + AW'(i)] <= wdata[8*i +: 8];
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// Pipeline register with synchronous reset, stall (hold) and bubble insert.
// Priority: reset, stall, bubble, load; stall with bubble holds.
module pipe_reg #(
    parameter int               WIDTH  = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset)
            q <= BUBBLE;
        else if (stall)
            q <= q;
        else if (bubble)
            q <= BUBBLE;
        else
            q <= d;
    end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M register, data memory access, memory status,
// and the W register feeding writeback.
module memory_stage
    import y86_defs::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        M_stall,
    input  logic        M_bubble,
    input  logic        W_stall,
    input  logic        W_bubble,
    input  logic [2:0]  e_stat,
    input  logic [3:0]  e_icode,
    input  logic        e_Cnd,
    input  logic [63:0] e_valE,
    input  logic [63:0] E_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  E_dstM,
    input  logic        ld_en,
    input  logic [63:0] ld_addr,
    input  logic [63:0] ld_data,
    output logic [2:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [63:0] m_valM,
    output logic [2:0]  m_stat,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    m_reg_t      m_d, m_q;
    w_reg_t      w_d, w_q;
    logic [63:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic        dmem_error;

    assign m_d = '{stat: e_stat, icode: e_icode, cnd: e_Cnd,
                   val_e: e_valE, val_a: E_valA,
                   dst_e: e_dstE, dst_m: E_dstM};

    pipe_reg #(.WIDTH($bits(m_reg_t)), .BUBBLE(M_BUBBLE)) u_m_reg (
        .clock  (clock),
        .reset  (reset),
        .stall  (M_stall),
        .bubble (M_bubble),
        .d      (m_d),
        .q      (m_q)
    );

    // Stack pops (POPQ, RET) address through valA; everything else through valE.
    always_comb begin
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (m_q.icode)
            I_RMMOVQ, I_PUSHQ, I_CALL: begin
                mem_addr  = m_q.val_e;
                mem_write = 1'b1;
            end
            I_MRMOVQ: begin
                mem_addr = m_q.val_e;
                mem_read = 1'b1;
            end
            I_POPQ, I_RET: begin
                mem_addr = m_q.val_a;
                mem_read = 1'b1;
            end
            default: ;
        endcase
    end

    data_mem #(.MEM_BYTES(MEM_BYTES)) u_dmem (
        .clock   (clock),
        .reset   (reset),
        .addr    (mem_addr),
        .rd      (mem_read),
        .wr      (mem_write),
        .wdata   (m_q.val_a),
        .rdata   (m_valM),
        .error   (dmem_error),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    assign m_stat = dmem_error ? S_ADR : m_q.stat;

    assign w_d = '{stat: m_stat, icode: m_q.icode,
                   val_e: m_q.val_e, val_m: m_valM,
                   dst_e: m_q.dst_e, dst_m: m_q.dst_m};

    pipe_reg #(.WIDTH($bits(w_reg_t)), .BUBBLE(W_BUBBLE)) u_w_reg (
        .clock  (clock),
        .reset  (reset),
        .stall  (W_stall),
        .bubble (W_bubble),
        .d      (w_d),
        .q      (w_q)
    );

    assign M_stat  = m_q.stat;
    assign M_icode = m_q.icode;
    assign M_Cnd   = m_q.cnd;
    assign M_valE  = m_q.val_e;
    assign M_valA  = m_q.val_a;
    assign M_dstE  = m_q.dst_e;
    assign M_dstM  = m_q.dst_m;

    assign W_stat  = w_q.stat;
    assign W_icode = w_q.icode;
    assign W_valE  = w_q.val_e;
    assign W_valM  = w_q.val_m;
    assign W_dstE  = w_q.dst_e;
    assign W_dstM  = w_q.dst_m;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table with a W-stage scoreboard,
// plus sequences for stall/bubble, load-port collision and mid-run reset.
module tb_memory_stage;

    localparam int MEM_BYTES = 1024;

    logic        clock = 1'b0;
    logic        reset, M_stall, M_bubble, W_stall, W_bubble;
    logic [2:0]  e_stat;
    logic [3:0]  e_icode;
    logic        e_Cnd;
    logic [63:0] e_valE, E_valA;
    logic [3:0]  e_dstE, E_dstM;
    logic        ld_en;
    logic [63:0] ld_addr, ld_data;
    logic [2:0]  M_stat, m_stat, W_stat;
    logic [3:0]  M_icode, M_dstE, M_dstM, W_icode, W_dstE, W_dstM;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA, m_valM, W_valE, W_valM;

    memory_stage #(.MEM_BYTES(MEM_BYTES)) dut (
        .clock(clock), .reset(reset),
        .M_stall(M_stall), .M_bubble(M_bubble), .W_stall(W_stall), .W_bubble(W_bubble),
        .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd), .e_valE(e_valE),
        .E_valA(E_valA), .e_dstE(e_dstE), .E_dstM(E_dstM),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .m_valM(m_valM), .m_stat(m_stat),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [63:0] exp_valm;
        logic [2:0]  exp_mstat;
    } vec_t;

    vec_t vecs[16];
    vec_t exp_q[$];
    vec_t w_exp;
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic [2:0] st, logic [3:0] ic, logic cn,
                                logic [63:0] ve, logic [63:0] va,
                                logic [3:0] de, logic [3:0] dm,
                                logic [63:0] xv, logic [2:0] xs);
        vec_t v;
        v.stat = st; v.icode = ic; v.cnd = cn; v.val_e = ve; v.val_a = va;
        v.dst_e = de; v.dst_m = dm; v.exp_valm = xv; v.exp_mstat = xs;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic cn,
                         input logic [63:0] ve, input logic [63:0] va,
                         input logic [3:0] de, input logic [3:0] dm);
        e_stat = st; e_icode = ic; e_Cnd = cn; e_valE = ve; E_valA = va;
        e_dstE = de; E_dstM = dm;
    endtask

    task automatic load(input logic [63:0] a, input logic [63:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic check_w(input string tag, input vec_t v);
        check({tag, " W_stat"},  64'(W_stat),  64'(v.exp_mstat));
        check({tag, " W_icode"}, 64'(W_icode), 64'(v.icode));
        check({tag, " W_valE"},  W_valE,       v.val_e);
        check({tag, " W_valM"},  W_valM,       v.exp_valm);
        check({tag, " W_dstM"},  64'(W_dstM),  64'(v.dst_m));
    endtask

    initial begin
        // stat, icode, cnd, valE, valA, dstE, dstM, expected m_valM, expected m_stat
        vecs[0]  = mk(3'd1, 4'h4, 0, 64'h100, 64'h1122334455667788, 4'hF, 4'hF, 64'h0, 3'd1);
        vecs[1]  = mk(3'd1, 4'h5, 0, 64'h100, 64'h0, 4'hF, 4'h3, 64'h1122334455667788, 3'd1);
        vecs[2]  = mk(3'd1, 4'h4, 0, 64'h0F9, 64'h0, 4'hF, 4'hF, 64'h0, 3'd1);
        vecs[3]  = mk(3'd1, 4'h5, 0, 64'h100, 64'h0, 4'hF, 4'h4, 64'h1122334455667700, 3'd1);
        vecs[4]  = mk(3'd1, 4'hB, 0, 64'h300, 64'h200, 4'h4, 4'h5, 64'h5, 3'd1);
        vecs[5]  = mk(3'd1, 4'h8, 0, 64'h3F8, 64'h40, 4'h4, 4'hF, 64'h0, 3'd1);
        vecs[6]  = mk(3'd1, 4'h5, 0, 64'(MEM_BYTES - 7), 64'h0, 4'hF, 4'h2, 64'h0, 3'd2);
        vecs[7]  = mk(3'd1, 4'h4, 0, 64'hFFFFFFFFFFFFFFF8, 64'hAA, 4'hF, 4'hF, 64'h0, 3'd2);
        vecs[8]  = mk(3'd1, 4'h5, 0, 64'h3F8, 64'h0, 4'hF, 4'h1, 64'h40, 3'd1);
        vecs[9]  = mk(3'd1, 4'h9, 0, 64'h400, 64'h3F8, 4'h4, 4'hF, 64'h40, 3'd1);
        vecs[10] = mk(3'd1, 4'h6, 1, 64'h1234, 64'h0, 4'h2, 4'hF, 64'h0, 3'd1);
        vecs[11] = mk(3'd3, 4'h3, 0, 64'h7, 64'h0, 4'h6, 4'hF, 64'h0, 3'd3);
        vecs[12] = mk(3'd1, 4'h5, 0, 64'h10, 64'h0, 4'hF, 4'h7, 64'hDEADBEEF, 3'd1);
        vecs[13] = mk(3'd1, 4'hA, 0, 64'h8, 64'hCAFE, 4'h4, 4'hF, 64'h0, 3'd1);
        vecs[14] = mk(3'd1, 4'h5, 0, 64'h8, 64'h0, 4'hF, 4'h8, 64'hCAFE, 3'd1);
        vecs[15] = mk(3'd4, 4'h0, 0, 64'h0, 64'h0, 4'hF, 4'hF, 64'h0, 3'd4);

        M_stall = 0; M_bubble = 0; W_stall = 0; W_bubble = 0;
        ld_en = 0; ld_addr = 0; ld_data = 0;
        drive(3'd1, 4'h1, 0, 0, 0, 4'hF, 4'hF);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        load(64'h200, 64'h5);
        load(64'h10, 64'hDEADBEEF);
        load(64'h40, 64'h55);
        load(64'h3F9, 64'hEE);

        drive(3'd1, 4'h6, 1, 64'h77, 64'h66, 4'h3, 4'h3);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst M_icode", 64'(M_icode), 64'h1);
        check("rst M_stat",  64'(M_stat),  64'h0);
        check("rst M_dstE",  64'(M_dstE),  64'hF);
        check("rst M_dstM",  64'(M_dstM),  64'hF);
        check("rst M_Cnd",   64'(M_Cnd),   64'h0);
        check("rst M_valE",  M_valE,       64'h0);
        check("rst M_valA",  M_valA,       64'h0);
        check("rst m_stat",  64'(m_stat),  64'h0);
        check("rst W_icode", 64'(W_icode), 64'h1);
        check("rst W_stat",  64'(W_stat),  64'h0);
        check("rst W_dstE",  64'(W_dstE),  64'hF);
        check("rst W_dstM",  64'(W_dstM),  64'hF);
        check("rst W_valM",  W_valM,       64'h0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].stat, vecs[i].icode, vecs[i].cnd, vecs[i].val_e,
                  vecs[i].val_a, vecs[i].dst_e, vecs[i].dst_m);
            exp_q.push_back(vecs[i]);
            tick();
            check($sformatf("v%0d M_icode", i), 64'(M_icode), 64'(vecs[i].icode));
            check($sformatf("v%0d M_valE", i),  M_valE,       vecs[i].val_e);
            check($sformatf("v%0d M_dstM", i),  64'(M_dstM),  64'(vecs[i].dst_m));
            check($sformatf("v%0d m_valM", i),  m_valM,       vecs[i].exp_valm);
            check($sformatf("v%0d m_stat", i),  64'(m_stat),  64'(vecs[i].exp_mstat));
            if (exp_q.size() > 1) begin
                w_exp = exp_q.pop_front();
                check_w($sformatf("v%0d", i - 1), w_exp);
            end
        end
        drive(3'd1, 4'h1, 0, 0, 0, 4'hF, 4'hF);
        tick();
        w_exp = exp_q.pop_front();
        check_w("v15", w_exp);

        // Load port and stage write hit overlapping bytes on the same edge.
        drive(3'd1, 4'h4, 0, 64'h100, 64'h0807060504030201, 4'hF, 4'hF);
        tick();
        ld_en = 1'b1; ld_addr = 64'h104; ld_data = 64'hF0F0F0F0F0F0F0F0;
        drive(3'd1, 4'h5, 0, 64'h104, 64'h0, 4'hF, 4'h1);
        tick();
        ld_en = 1'b0;
        check("collide 0x104", m_valM, 64'hF0F0F0F008070605);
        drive(3'd1, 4'h5, 0, 64'h100, 64'h0, 4'hF, 4'h1);
        tick();
        check("collide 0x100", m_valM, 64'h0807060504030201);

        // Stall and bubble handling.
        drive(3'd1, 4'h5, 0, 64'h200, 64'h0, 4'hF, 4'h6);
        tick();
        check("stall pre m_valM", m_valM, 64'h5);
        M_stall = 1'b1;
        drive(3'd1, 4'h6, 1, 64'h999, 64'h0, 4'h2, 4'hF);
        tick();
        check("stall1 M_icode", 64'(M_icode), 64'h5);
        check("stall1 M_valE",  M_valE,       64'h200);
        tick();
        check("stall2 M_icode", 64'(M_icode), 64'h5);
        check("stall2 M_dstM",  64'(M_dstM),  64'h6);
        check("stall2 W_valM",  W_valM,       64'h5);
        check("stall2 W_dstM",  64'(W_dstM),  64'h6);
        M_bubble = 1'b1;
        tick();
        check("stall+bub M_icode", 64'(M_icode), 64'h5);
        check("stall+bub M_valE",  M_valE,       64'h200);
        M_stall = 1'b0;
        tick();
        M_bubble = 1'b0;
        check("bub M_icode", 64'(M_icode), 64'h1);
        check("bub M_stat",  64'(M_stat),  64'h0);
        check("bub M_dstM",  64'(M_dstM),  64'hF);
        check("bub W_valM",  W_valM,       64'h5);
        W_stall = 1'b1;
        tick();
        check("W stall M_icode", 64'(M_icode), 64'h6);
        check("W stall W_icode", 64'(W_icode), 64'h5);
        check("W stall W_valM",  W_valM,       64'h5);
        W_stall = 1'b0; W_bubble = 1'b1;
        tick();
        W_bubble = 1'b0;
        check("W bub W_icode", 64'(W_icode), 64'h1);
        check("W bub W_stat",  64'(W_stat),  64'h0);
        check("W bub W_dstE",  64'(W_dstE),  64'hF);
        check("W bub W_valE",  W_valE,       64'h0);

        // Reset while a store sits in M: the store must be dropped.
        drive(3'd1, 4'h4, 0, 64'h40, 64'h77, 4'hF, 4'hF);
        tick();
        reset = 1'b1;
        drive(3'd1, 4'h1, 0, 0, 0, 4'hF, 4'hF);
        tick();
        reset = 1'b0;
        check("midrst M_icode", 64'(M_icode), 64'h1);
        check("midrst W_icode", 64'(W_icode), 64'h1);
        check("midrst W_stat",  64'(W_stat),  64'h0);
        drive(3'd1, 4'h5, 0, 64'h40, 64'h0, 4'hF, 4'h1);
        tick();
        check("midrst mem 0x40", m_valM, 64'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Memory stage of the 5-stage Y86-64 pipeline. It is the consumer end of the execute-stage outputs: the M pipeline register captures valE, Cnd, dst registers, icode and stat from execute. The stage performs the data-memory access and computes the memory-stage status. It then loads the W pipeline register that feeds writeback, and exposes M/m/W values for forwarding and pipeline control.

Parameters:
MEM_BYTES, 1024, size of byte-addressable data memory
RNONE, 4'hF, "no register" destination id; bubble value for dst fields

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high; loads bubble into M and W registers
M_stall  in  1  hold M register
M_bubble  in  1  load bubble into M register
W_stall  in  1  hold W register
W_bubble  in  1  load bubble into W register
e_stat  in  3  status from execute
e_icode  in  4  icode from execute
e_Cnd  in  1  condition result from execute
e_valE  in  64  ALU result
E_valA  in  64  valA carried through execute
e_dstE  in  4  destination E (already Cnd-gated by execute)
E_dstM  in  4  destination M
ld_en  in  1  test/program-load write enable
ld_addr  in  64  byte address for load port
ld_data  in  64  word for load port
M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM  out  3/4/1/64/64/4/4  M register contents
m_valM  out  64  data read this cycle
m_stat  out  3  memory-stage status
W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM  out  3/4/64/64/4/4  W register contents

Behaviour:
- Codes. icode: HALT 0, NOP 1, RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B. stat: SBUB 0, SAOK 1, SADR 2, SINS 3, SHLT 4.
- Bubble value for M and W: stat SBUB, icode NOP, Cnd 0, valE/valA/valM 0, dstE/dstM RNONE.
- Pipeline registers. Per-register priority at posedge: reset, then stall (hold), then bubble, then load. Stall together with bubble means hold.
- Reset is synchronous. On the reset edge both registers take bubble and no memory write occurs. Memory contents are not cleared. Reset asserted mid-operation discards in-flight M/W contents on that edge.
- Address (combinational from M): M_valE for RMMOVQ, PUSHQ, CALL, MRMOVQ; M_valA for POPQ, RET; 0 otherwise.
- mem_read: MRMOVQ, POPQ, RET. mem_write: RMMOVQ, PUSHQ, CALL.
- Write data is M_valA. Words are 8 bytes, little-endian.
- dmem_error = (mem_read|mem_write) & (addr > MEM_BYTES-8). Use 64-bit unsigned compare; no wrap, so an address near 2^64 is an error.
- m_valM is combinational, same cycle. It is mem[addr..addr+7] when mem_read & ~dmem_error, else 0.
- m_stat = dmem_error ? SADR : M_stat.
- Memory write commits at the posedge when mem_write & ~dmem_error & ~reset. The write is visible to a read in the following cycle (read-after-write one cycle later). A stalled M repeats the write, which is idempotent.
- The ld_en write commits at posedge with the same 8-byte little-endian rule. It is ignored when out of range. If it coincides with a stage write to an overlapping address, the stage write wins per byte.
- W load values: W_stat←m_stat, W_icode←M_icode, W_valE←M_valE, W_valM←m_valM, W_dstE←M_dstE, W_dstM←M_dstM.
- Latency: execute outputs appear on M_* one cycle after capture, and on W_* one cycle later.
- No suppression of writes on exception status inside this block; pipeline control bubbles M for that.

Decomposition:
- Shared package y86_defs: icode constants, stat codes, RNONE, word width 64.
- One sub-module, data_mem: byte array, combinational 8-byte read, clocked write, load port, error flag.
- Both pipeline registers use the team's stall/bubble register module with reset added.

Test Plan:
- Reset for 1 cycle → M_icode=1, M_stat=0, M_dstE=F, W_* bubble. Memory preloaded via ld_en is still readable afterwards.
- RMMOVQ: e_valE=0x100, E_valA=0x1122334455667788 captured. Next cycle MRMOVQ at 0x100 → m_valM=0x1122334455667788. Byte 0x100 must be 0x88 (check via MRMOVQ at 0x100 after a second write at 0x0F9 of 0).
- POPQ with M_valA=0x200, mem[0x200]=5 → m_valM=5, address taken from valA not valE. Next cycle W_valM=5, W_dstM=E_dstM.
- MRMOVQ at valE=MEM_BYTES-7 → m_stat=SADR, m_valM=0. RMMOVQ at 0xFFFFFFFFFFFFFFF8 → no write, m_stat=SADR.
- M_stall=1 for 2 cycles with new execute inputs → M_* unchanged. M_stall and M_bubble together → hold. M_bubble alone → NOP/SBUB.
- CALL: valE=0x3F8, valA=0x40 → mem word at 0x3F8 becomes 0x40. W_stat=SAOK, W_valE=0x3F8.
